zap_intr_ctrl: RTL

- Interrupt controller that drives the register file's i_irq/i_fiq inputs and consumes its o_irq_ack/o_fiq_ack pulses.
- Synchronises NUM_SRC external lines, detects edges or levels per source, and holds pending state.
- Applies enable, FIQ routing and CPSR I/F masks, and reports the in-service source ID.
- Software configures it through a small word-addressed register port and ends each handler with an EOI write.

---
 rtl/zap_intr_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/zap_intr_ctrl.sv
// Interrupt controller feeding the register file's IRQ/FIQ inputs.
// Synchronises sources, tracks pending state and runs one request/service FSM per class.
module zap_intr_ctrl #(
    parameter int unsigned NUM_SRC     = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_SRC-1:0] i_src,
    input  logic               i_cpsr_i,
    input  logic               i_cpsr_f,
    input  logic               i_irq_ack,
    input  logic               i_fiq_ack,
    input  logic               i_wr_en,
    input  logic               i_rd_en,
    input  logic [2:0]         i_addr,
    input  logic [31:0]        i_wr_data,
    output logic [31:0]        o_rd_data,
    output logic               o_rd_valid,
    output logic               o_irq,
    output logic               o_fiq
);
    localparam int unsigned ID_W = 5;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

    logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_fiq_sel;
    logic [NUM_SRC-1:0] r_edge;
    logic [NUM_SRC-1:0] r_pending;
    state_t             r_irq_state;
    state_t             r_fiq_state;
    logic               r_irq_valid;
    logic               r_fiq_valid;
    logic [ID_W-1:0]    r_irq_id;
    logic [ID_W-1:0]    r_fiq_id;

    logic [NUM_SRC-1:0] w_sync;
    logic [NUM_SRC-1:0] w_wr_data;
    logic [NUM_SRC-1:0] w_irq_cand;
    logic [NUM_SRC-1:0] w_fiq_cand;
    logic [ID_W-1:0]    w_irq_sel;
    logic [ID_W-1:0]    w_fiq_sel;
    logic               w_irq_take;
    logic               w_fiq_take;
    logic               w_irq_eoi;
    logic               w_fiq_eoi;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic [31:0]        w_rd_mux;
    logic               w_unused;

    // Fixed priority: lowest set index wins.
    function automatic logic [ID_W-1:0] f_lowest(input logic [NUM_SRC-1:0] v);
        f_lowest = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (v[i]) f_lowest = ID_W'(i);
        end
    endfunction

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_wr_data  = i_wr_data[NUM_SRC-1:0];
    assign w_unused   = &{1'b0, i_wr_data};
    assign w_irq_cand = r_pending & r_enable & ~r_fiq_sel;
    assign w_fiq_cand = r_pending & r_enable & r_fiq_sel;
    assign w_irq_sel  = f_lowest(w_irq_cand);
    assign w_fiq_sel  = f_lowest(w_fiq_cand);
    assign w_irq_take = (r_irq_state == S_REQ) && i_irq_ack;
    assign w_fiq_take = (r_fiq_state == S_REQ) && i_fiq_ack;
    assign w_irq_eoi  = i_wr_en && (i_addr == 3'd6) && i_wr_data[0];
    assign w_fiq_eoi  = i_wr_en && (i_addr == 3'd6) && i_wr_data[1];
    assign w_w1c      = (i_wr_en && (i_addr == 3'd3)) ? w_wr_data : '0;

    assign w_ack_clr = ((w_irq_take && (|w_irq_cand)) ? (NUM_SRC'(1) << w_irq_sel) : '0)
                     | ((w_fiq_take && (|w_fiq_cand)) ? (NUM_SRC'(1) << w_fiq_sel) : '0);

    // Edge sources: a fresh rise beats any clear in the same cycle; level sources track the line.
    assign w_pending_nxt = (r_edge & ((r_pending & ~(w_w1c | w_ack_clr)) | (w_sync & ~r_prev)))
                         | (~r_edge & w_sync);

    always_comb begin
        w_rd_mux = '0;
        case (i_addr)
            3'd0:    w_rd_mux = 32'(r_enable);
            3'd1:    w_rd_mux = 32'(r_fiq_sel);
            3'd2:    w_rd_mux = 32'(r_edge);
            3'd3:    w_rd_mux = 32'(r_pending);
            3'd4:    w_rd_mux = {r_irq_valid, 26'd0, r_irq_id};
            3'd5:    w_rd_mux = {r_fiq_valid, 26'd0, r_fiq_id};
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned j = 0; j < SYNC_STAGES; j++) r_sync[j] <= '0;
            r_prev     <= '0;
            r_enable   <= '0;
            r_fiq_sel  <= '0;
            r_edge     <= '0;
            r_pending  <= '0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            r_sync[0] <= i_src;
            for (int unsigned j = 1; j < SYNC_STAGES; j++) r_sync[j] <= r_sync[j-1];
            r_prev     <= w_sync;
            r_pending  <= w_pending_nxt;
            o_rd_valid <= i_rd_en;
            if (i_rd_en) o_rd_data <= w_rd_mux;
            if (i_wr_en && (i_addr == 3'd0)) r_enable  <= w_wr_data;
            if (i_wr_en && (i_addr == 3'd1)) r_fiq_sel <= w_wr_data;
            if (i_wr_en && (i_addr == 3'd2)) r_edge    <= w_wr_data;
        end
    end

    // IRQ and FIQ request/service FSMs; output is high only while in REQ.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irq_state <= S_IDLE;
            r_fiq_state <= S_IDLE;
            r_irq_valid <= 1'b0;
            r_fiq_valid <= 1'b0;
            r_irq_id    <= '0;
            r_fiq_id    <= '0;
            o_irq       <= 1'b0;
            o_fiq       <= 1'b0;
        end else begin
            case (r_irq_state)
                S_IDLE: if ((|w_irq_cand) && !i_cpsr_i) begin
                    r_irq_state <= S_REQ;
                    o_irq       <= 1'b1;
                end
                S_REQ: if (i_irq_ack) begin
                    r_irq_state <= S_SERVICE;
                    r_irq_valid <= 1'b1;
                    r_irq_id    <= w_irq_sel;
                    o_irq       <= 1'b0;
                end else if (!(|w_irq_cand) || i_cpsr_i) begin
                    r_irq_state <= S_IDLE;
                    o_irq       <= 1'b0;
                end
                S_SERVICE: if (w_irq_eoi) begin
                    r_irq_state <= S_IDLE;
                    r_irq_valid <= 1'b0;
                end
                default: begin
                    r_irq_state <= S_IDLE;
                    o_irq       <= 1'b0;
                end
            endcase

            case (r_fiq_state)
                S_IDLE: if ((|w_fiq_cand) && !i_cpsr_f) begin
                    r_fiq_state <= S_REQ;
                    o_fiq       <= 1'b1;
                end
                S_REQ: if (i_fiq_ack) begin
                    r_fiq_state <= S_SERVICE;
                    r_fiq_valid <= 1'b1;
                    r_fiq_id    <= w_fiq_sel;
                    o_fiq       <= 1'b0;
                end else if (!(|w_fiq_cand) || i_cpsr_f) begin
                    r_fiq_state <= S_IDLE;
                    o_fiq       <= 1'b0;
                end
                S_SERVICE: if (w_fiq_eoi) begin
                    r_fiq_state <= S_IDLE;
                    r_fiq_valid <= 1'b0;
                end
                default: begin
                    r_fiq_state <= S_IDLE;
                    o_fiq       <= 1'b0;
                end
            endcase
        end
    end
endmodule
